// File: rtl/riscv_xcache_bus_v2.sv
// riscv_xcache_bus_v2: round-robin mux of RISC-V channels onto one memory port, in-order read-return routing. Rev 1.0
// Define RV_XCACHE_BUS_PERF_EN to build the per-channel stall counters (otherwise perf_stall_cnt is tied to 0).
`default_nettype none

module riscv_xcache_bus_v2 #(
  parameter int RV_NUM       = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int OUTSTD_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      rv_part        [RV_NUM],
  input  logic                            rv_re          [RV_NUM],
  input  logic [DATA_WIDTH/8-1:0]         rv_we          [RV_NUM],
  input  logic [ADDR_WIDTH-1:0]           rv_addr        [RV_NUM],
  input  logic [DATA_WIDTH-1:0]           rv_wdata       [RV_NUM],
  output logic                            rv_ready       [RV_NUM],
  output logic                            rv_valid       [RV_NUM],
  output logic [DATA_WIDTH-1:0]           rv_rdata       [RV_NUM],
  input  logic                            mem_rdy,
  output logic [7:0]                      mem_part,
  output logic                            mem_re,
  output logic [DATA_WIDTH/8-1:0]         mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_ad,
  output logic [DATA_WIDTH-1:0]           mem_di,
  input  logic [DATA_WIDTH-1:0]           mem_do,
  input  logic                            mem_do_vld,
  output logic [$clog2(OUTSTD_DEPTH):0]   outstd_cnt,
  output logic                            err_unexp_vld,
  output logic [31:0]                     perf_stall_cnt [RV_NUM]
);

  localparam int IDX_W = (RV_NUM > 1) ? $clog2(RV_NUM) : 1;
  localparam int PTR_W = $clog2(OUTSTD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RV_NUM-1:0] req;
  logic [RV_NUM-1:0] elig;
  logic [RV_NUM-1:0] pend;
  logic [IDX_W-1:0]  rrpt;
  logic [IDX_W-1:0]  rrpt_nxt;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  head;
  logic              grant_valid;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IDX_W-1:0]  fifo_mem [OUTSTD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign fifo_full  = (outstd_cnt == CNT_W'(OUTSTD_DEPTH));
  assign fifo_empty = (outstd_cnt == '0);

  always_comb begin
    for (int i = 0; i < RV_NUM; i++) begin
      req[i]  = rv_re[i] | (|rv_we[i]);
      elig[i] = req[i] & ~pend[i] & (~rv_re[i] | ~fifo_full);
    end
  end

  // Scan downward so the eligible channel closest to rrpt is the last one written.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = RV_NUM - 1; k >= 0; k--) begin
      if (elig[(int'(rrpt) + k) % RV_NUM]) begin
        grant_valid = 1'b1;
        grant       = IDX_W'((int'(rrpt) + k) % RV_NUM);
      end
    end
  end

  assign accept   = grant_valid & mem_rdy;
  assign rrpt_nxt = (int'(grant) == RV_NUM - 1) ? '0 : grant + 1'b1;
  assign push     = accept & rv_re[grant] & ~fifo_full;
  assign pop      = mem_do_vld & ~fifo_empty;
  assign head     = fifo_mem[rd_ptr];

  assign mem_part = rv_part[grant];
  assign mem_ad   = rv_addr[grant];
  assign mem_di   = rv_wdata[grant];
  assign mem_re   = grant_valid & rv_re[grant];
  assign mem_we   = grant_valid ? rv_we[grant] : '0;

  always_comb begin
    for (int i = 0; i < RV_NUM; i++) begin
      rv_ready[i] = accept & (int'(grant) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrpt          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstd_cnt    <= '0;
      pend          <= '0;
      err_unexp_vld <= 1'b0;
      for (int i = 0; i < RV_NUM; i++) begin
        rv_valid[i] <= 1'b0;
        rv_rdata[i] <= '0;
      end
    end else begin
      if (accept) begin
        rrpt <= rrpt_nxt;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        outstd_cnt <= outstd_cnt + 1'b1;
      end else if (pop && !push) begin
        outstd_cnt <= outstd_cnt - 1'b1;
      end
      if (mem_do_vld && fifo_empty) begin
        err_unexp_vld <= 1'b1;
      end
      for (int i = 0; i < RV_NUM; i++) begin
        rv_valid[i] <= pop & (int'(head) == i);
        if (pop && int'(head) == i) begin
          rv_rdata[i] <= mem_do;
          pend[i]     <= 1'b0;
        end
        if (push && int'(grant) == i) begin
          pend[i] <= 1'b1;
        end
      end
    end
  end

`ifdef RV_XCACHE_BUS_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RV_NUM; i++) begin
        perf_stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RV_NUM; i++) begin
        if (req[i] && !rv_ready[i] && perf_stall_cnt[i] != 32'hFFFF_FFFF) begin
          perf_stall_cnt[i] <= perf_stall_cnt[i] + 32'd1;
        end
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < RV_NUM; i++) begin
      perf_stall_cnt[i] = '0;
    end
  end
`endif

endmodule

`default_nettype wire
